// File: rtl/wash_sched.sv
// wash_sched: timed forward/stop/reverse/stop agitation sequencer for the washer motor.
// Seconds come from a FREQ-cycle prescaler; completion is flagged on compl_n.
module wash_sched #(
    parameter int FREQ = 8,
    parameter int TW   = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          pause,
    input  logic [TW-1:0] run_sec,
    input  logic [3:0]    fwd_sec,
    input  logic [3:0]    rev_sec,
    input  logic [3:0]    stop_sec,
    output logic [1:0]    motor,
    output logic          compl_n,
    output logic          busy,
    output logic [TW-1:0] remaining
);
    localparam int PW = $clog2(FREQ);
    localparam logic [PW-1:0] PRE_MAX = PW'(FREQ - 1);

    typedef enum logic [2:0] {IDLE, FWD, STOP1, REV, STOP2, DONE} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [TW-1:0] rem_q, rem_d, rem_dec;
    logic [3:0]    phase_q, phase_d, phase_dec;
    logic [3:0]    fwd_q, fwd_d, rev_q, rev_d, stop_q, stop_d;
    logic [1:0]    motor_q, motor_d;
    logic          counting, tick, accept;

    assign busy      = state_q inside {FWD, STOP1, REV, STOP2};
    assign compl_n   = state_q != DONE;
    assign remaining = rem_q;
    assign motor     = motor_q;
    assign counting  = busy && !pause;
    assign tick      = counting && pre_q == PRE_MAX;
    assign accept    = start && (state_q == IDLE || state_q == DONE);
    assign phase_dec = phase_q - 4'd1;
    assign rem_dec   = (rem_q != '0) ? rem_q - TW'(1) : rem_q;

    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        rem_d   = rem_q;
        phase_d = phase_q;
        fwd_d   = fwd_q;
        rev_d   = rev_q;
        stop_d  = stop_q;
        if (accept) begin
            fwd_d   = (fwd_sec == 4'd0) ? 4'd1 : fwd_sec;
            rev_d   = (rev_sec == 4'd0) ? 4'd1 : rev_sec;
            stop_d  = (stop_sec == 4'd0) ? 4'd1 : stop_sec;
            rem_d   = run_sec;
            pre_d   = '0;
            phase_d = fwd_d;
            state_d = (run_sec == '0) ? DONE : FWD;
        end else if (counting) begin
            pre_d = tick ? '0 : pre_q + PW'(1);
            if (tick) begin
                rem_d   = rem_dec;
                phase_d = phase_dec;
                // Program expiry wins over a phase boundary on the same tick
                if (rem_dec == '0) begin
                    state_d = DONE;
                end else if (phase_dec == 4'd0) begin
                    state_d = state_q == FWD ? STOP1 : state_q == STOP1 ? REV :
                              state_q == REV ? STOP2 : FWD;
                    phase_d = state_q == STOP1 ? rev_q : state_q == STOP2 ? fwd_q : stop_q;
                end
            end
        end
        motor_d = pause ? 2'b00 : state_d == FWD ? 2'b01 : state_d == REV ? 2'b10 : 2'b00;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pre_q   <= '0;
            rem_q   <= '0;
            phase_q <= 4'd1;
            fwd_q   <= 4'd1;
            rev_q   <= 4'd1;
            stop_q  <= 4'd1;
            motor_q <= 2'b00;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            rem_q   <= rem_d;
            phase_q <= phase_d;
            fwd_q   <= fwd_d;
            rev_q   <= rev_d;
            stop_q  <= stop_d;
            motor_q <= motor_d;
        end
    end
endmodule

// File: tb/tb_wash_sched.sv
// tb_wash_sched: scoreboard bench; stimulus queues expected output changes,
// a negedge monitor pops and compares each observed change of the outputs.
module tb_wash_sched;
    localparam int FREQ = 8;
    localparam int TW   = 8;

    logic          clk = 0, rst_n = 1, start = 0, pause = 0;
    logic [TW-1:0] run_sec = 0;
    logic [3:0]    fwd_sec = 0, rev_sec = 0, stop_sec = 0;
    logic [1:0]    motor;
    logic          compl_n, busy;
    logic [TW-1:0] remaining;

    typedef struct {
        int            t;
        logic [1:0]    m;
        logic          c;
        logic          b;
        logic [TW-1:0] r;
    } ev_t;

    ev_t           q[$];
    ev_t           e;
    int            cyc = 0, checks = 0, failures = 0, k = 0;
    logic [1:0]    pm = 0;
    logic          pc = 1, pb = 0;
    logic [TW-1:0] pr = 0;

    wash_sched #(.FREQ(FREQ), .TW(TW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pause(pause),
        .run_sec(run_sec), .fwd_sec(fwd_sec), .rev_sec(rev_sec), .stop_sec(stop_sec),
        .motor(motor), .compl_n(compl_n), .busy(busy), .remaining(remaining)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && {motor, compl_n, busy, remaining} != {pm, pc, pb, pr}) begin
            if (motor != pm) begin
                checks++;
                if ({pm, motor} == 4'b0110 || {pm, motor} == 4'b1001) begin
                    failures++;
                    $display("FAIL dir_safety cyc=%0d motor %b->%b required a stop between", cyc, pm, motor);
                end
            end
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_change cyc=%0d got m=%b c=%b b=%b r=%0d required no change",
                         cyc, motor, compl_n, busy, remaining);
            end else begin
                e = q.pop_front();
                if (e.t != cyc || e.m !== motor || e.c !== compl_n || e.b !== busy || e.r !== remaining) begin
                    failures++;
                    $display("FAIL event cyc=%0d m=%b c=%b b=%b r=%0d required cyc=%0d m=%b c=%b b=%b r=%0d",
                             cyc, motor, compl_n, busy, remaining, e.t, e.m, e.c, e.b, e.r);
                end
            end
        end
        pm = motor; pc = compl_n; pb = busy; pr = remaining;
    end

    task automatic chk(string name, logic [TW-1:0] got, logic [TW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d required=%0d", name, got, exp);
        end
    endtask

    task automatic chk_reset();
        chk("rst_motor", TW'(motor), 0);
        chk("rst_busy", TW'(busy), 0);
        chk("rst_compl_n", TW'(compl_n), 1);
        chk("rst_remaining", remaining, 0);
    endtask

    task automatic push(int dt, logic [1:0] m, logic c, logic b, logic [TW-1:0] r);
        q.push_back('{k + dt, m, c, b, r});
    endtask

    // Start is sampled at edge k; inputs are then scrambled to prove they were latched
    task automatic go(logic [TW-1:0] rs, logic [3:0] f, logic [3:0] s, logic [3:0] rv);
        @(posedge clk); #1;
        start = 1; run_sec = rs; fwd_sec = f; stop_sec = s; rev_sec = rv;
        k = cyc + 1;
        @(posedge clk); #1;
        start = 0; run_sec = ~rs; fwd_sec = ~f; stop_sec = ~s; rev_sec = ~rv;
    endtask

    task automatic basic_ev();
        push(0, 2'b01, 1, 1, 6);
        push(8, 2'b01, 1, 1, 5);
        push(16, 2'b00, 1, 1, 4);
        push(24, 2'b10, 1, 1, 3);
        push(32, 2'b10, 1, 1, 2);
        push(40, 2'b00, 1, 1, 1);
        push(48, 2'b00, 0, 0, 0);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required 0", q.size());
            q.delete();
        end
        repeat (6) @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        #2 rst_n = 0;
        #1 chk_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;

        go(0, 3, 3, 3);
        push(0, 2'b00, 0, 0, 0);
        drain();

        go(6, 2, 1, 2);
        basic_ev();
        drain();

        go(3, 0, 0, 0);
        push(0, 2'b01, 1, 1, 3);
        push(8, 2'b00, 1, 1, 2);
        push(16, 2'b10, 1, 1, 1);
        push(24, 2'b00, 0, 0, 0);
        drain();

        go(6, 2, 1, 2);
        push(0, 2'b01, 1, 1, 6);
        push(8, 2'b01, 1, 1, 5);
        push(16, 2'b00, 1, 1, 4);
        push(24, 2'b10, 1, 1, 3);
        push(28, 2'b00, 1, 1, 3);
        push(48, 2'b10, 1, 1, 3);
        push(52, 2'b10, 1, 1, 2);
        push(60, 2'b00, 1, 1, 1);
        push(68, 2'b00, 0, 0, 0);
        repeat (27) @(posedge clk);
        #1 pause = 1;
        repeat (20) @(posedge clk);
        #1 pause = 0;
        drain();

        go(6, 2, 1, 2);
        basic_ev();
        repeat (4) @(posedge clk);
        #1 start = 1; run_sec = 1; fwd_sec = 5; stop_sec = 3; rev_sec = 7;
        @(posedge clk);
        #1 start = 0;
        drain();

        go(6, 2, 1, 2);
        push(0, 2'b01, 1, 1, 6);
        push(8, 2'b01, 1, 1, 5);
        push(16, 2'b00, 1, 1, 4);
        repeat (20) @(posedge clk);
        #1 rst_n = 0;
        #1 chk_reset();
        repeat (5) @(posedge clk);
        #1 rst_n = 1;
        drain();
        go(6, 2, 1, 2);
        basic_ev();
        drain();

        go(4, 1, 2, 1);
        push(0, 2'b01, 1, 1, 4);
        push(8, 2'b00, 1, 1, 3);
        push(16, 2'b00, 1, 1, 2);
        push(24, 2'b10, 1, 1, 1);
        push(32, 2'b00, 0, 0, 0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
